// File: rtl/conv_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : conv_wr_arb                                                    |
// | Brief   : Arbitrates NREQ requester writes into NREG holding registers   |
// |           using an IDLE -> WRITE -> RECOVER sequence. All outputs are    |
// |           registered.                                                    |
// |           Define CONV_WR_ARB_RR_EN for round-robin arbitration.          |
// |           Without it, requester 0 has the highest fixed priority.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module conv_wr_arb #(
  parameter int DW   = 8,
  parameter int NREQ = 4,
  parameter int NREG = 4
) (
  input  logic              rcc_clk,
  input  logic              rcc_rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREG-1:0]   reg_en,
  output logic [DW-1:0]     reg_din,
  output logic              busy,
  output logic [7:0]        wr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREG-1:0] reg_en_q, reg_en_d;
  logic [DW-1:0]   reg_din_q, reg_din_d;
  logic            busy_q, busy_d;
  logic [7:0]      wr_cnt_q, wr_cnt_d;

  logic            found;
  logic [1:0]      win;
  logic [1:0]      sel_addr;
  logic [DW-1:0]   sel_data;

`ifdef CONV_WR_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;

  // Search begins at the pointer and wraps around the four requesters.
  always_comb begin
    found    = 1'b0;
    win      = 2'd0;
    sel_addr = 2'd0;
    sel_data = '0;
    idx      = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + i[1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = idx;
        sel_addr = req_addr[2*idx +: 2];
        sel_data = req_data[DW*idx +: DW];
      end
    end
  end
`else
  always_comb begin
    found    = 1'b0;
    win      = 2'd0;
    sel_addr = 2'd0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        win      = i[1:0];
        sel_addr = req_addr[2*i +: 2];
        sel_data = req_data[DW*i +: DW];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    reg_en_d  = '0;
    reg_din_d = reg_din_q;
    wr_cnt_d  = wr_cnt_q;
`ifdef CONV_WR_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_WRITE;
          reg_en_d  = NREG'(1) << sel_addr;
          ack_d     = NREQ'(1) << win;
          reg_din_d = sel_data;
`ifdef CONV_WR_ARB_RR_EN
          ptr_d     = win + 2'd1;
`endif
        end
      end
      ST_WRITE: begin
        // The write is counted only once its full WRITE cycle has completed.
        state_d  = ST_RECOVER;
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
    if (!rcc_rst_n) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      reg_en_q  <= '0;
      reg_din_q <= '0;
      busy_q    <= 1'b0;
      wr_cnt_q  <= 8'd0;
`ifdef CONV_WR_ARB_RR_EN
      ptr_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      reg_en_q  <= reg_en_d;
      reg_din_q <= reg_din_d;
      busy_q    <= busy_d;
      wr_cnt_q  <= wr_cnt_d;
`ifdef CONV_WR_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign ack     = ack_q;
  assign reg_en  = reg_en_q;
  assign reg_din = reg_din_q;
  assign busy    = busy_q;
  assign wr_cnt  = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_conv_wr_arb                                                 |
// | Brief   : Scoreboard bench for conv_wr_arb: the stimulus process queues  |
// |           each expected grant and the monitor checks it when ack fires.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_conv_wr_arb;

  logic        rcc_clk = 1'b0;
  logic        rcc_rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [3:0]  reg_en;
  logic [7:0]  reg_din;
  logic        busy;
  logic [7:0]  wr_cnt;

  conv_wr_arb #(.DW(8), .NREQ(4), .NREG(4)) dut (
    .rcc_clk   (rcc_clk),
    .rcc_rst_n (rcc_rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .reg_en    (reg_en),
    .reg_din   (reg_din),
    .busy      (busy),
    .wr_cnt    (wr_cnt)
  );

  always #5 rcc_clk = ~rcc_clk;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] en;
    logic [7:0] din;
  } exp_t;

  exp_t       expq[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] hold [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holding registers capture on the falling edge, mid WRITE cycle.
  always @(negedge rcc_clk or negedge rcc_rst_n) begin
    if (!rcc_rst_n) begin
      for (int k = 0; k < 4; k++) hold[k] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) if (reg_en[k]) hold[k] <= reg_din;
    end
  end

  always @(negedge rcc_clk) begin
    exp_t e;
    if (rcc_rst_n) begin
      if (ack != 4'b0000) begin
        if (expq.size() == 0) begin
          check("unexpected_ack", {28'd0, ack}, 32'd0);
        end else begin
          e = expq.pop_front();
          check("mon_ack", {28'd0, ack}, {28'd0, e.ack});
          check("mon_reg_en", {28'd0, reg_en}, {28'd0, e.en});
          check("mon_reg_din", {24'd0, reg_din}, {24'd0, e.din});
        end
      end else begin
        check("idle_reg_en", {28'd0, reg_en}, 32'd0);
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] en, input logic [7:0] din);
    exp_t e;
    e.ack = a; e.en = en; e.din = din;
    expq.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] addr, input logic [7:0] data);
    req_addr[2*i +: 2] = addr;
    req_data[8*i +: 8] = data;
  endtask

  // Returns the number of falling edges until ack is seen.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge rcc_clk);
      n++;
    end while (ack == 4'b0000 && n < 20);
    check("ack_timeout", {31'd0, ack != 4'b0000}, 32'd1);
  endtask

  task automatic do_reset();
    req = 4'b0000;
    @(negedge rcc_clk);
    rcc_rst_n = 1'b0;
    @(negedge rcc_clk);
    @(negedge rcc_clk);
    rcc_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [1:0] w;
    logic [1:0] exp_w [3];

    // Reset state
    rcc_rst_n = 1'b0;
    @(negedge rcc_clk);
    @(negedge rcc_clk);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_reg_en", {28'd0, reg_en}, 32'd0);
    check("rst_reg_din", {24'd0, reg_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    rcc_rst_n = 1'b1;
    @(negedge rcc_clk);

    // Single write, then a request that exists only outside IDLE
    set_req(0, 2'd2, 8'h5A);
    req = 4'b0001;
    push(4'b0001, 4'b0100, 8'h5A);
    wait_ack(n);
    check("single_latency", n, 1);
    check("write_busy", {31'd0, busy}, 32'd1);
    check("write_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    req = 4'b0100;
    set_req(2, 2'd3, 8'hEE);
    @(negedge rcc_clk);
    check("recover_wr_cnt", {24'd0, wr_cnt}, 32'd1);
    check("recover_reg_din", {24'd0, reg_din}, 32'h5A);
    check("recover_busy", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    repeat (6) @(negedge rcc_clk);
    check("dropped_wr_cnt", {24'd0, wr_cnt}, 32'd1);
    check("dropped_busy", {31'd0, busy}, 32'd0);
    check("hold2", {24'd0, hold[2]}, 32'h5A);

    // Two requesters to the same register: arbitration order, last wins
    do_reset();
    set_req(0, 2'd1, 8'h11);
    set_req(2, 2'd1, 8'h22);
    req = 4'b0101;
    push(4'b0001, 4'b0010, 8'h11);
    push(4'b0100, 4'b0010, 8'h22);
    wait_ack(n);
    req[0] = 1'b0;
    wait_ack(n);
    check("same_reg_gap", n, 3);
    req[2] = 1'b0;
    @(negedge rcc_clk);
    check("same_reg_din", {24'd0, reg_din}, 32'h22);
    check("hold1", {24'd0, hold[1]}, 32'h22);

    // All four requesting, each dropped after its ack
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i[1:0], 8'h30 + 8'(i));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) push(4'b0001 << i, 4'b0001 << i, 8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      if (i > 0) check("all4_gap", n, 3);
      req[i] = 1'b0;
    end
    @(negedge rcc_clk);
    check("all4_wr_cnt", {24'd0, wr_cnt}, 32'd4);

    // req1 keeps re-asserting against req3
    set_req(1, 2'd0, 8'hA1);
    set_req(3, 2'd3, 8'hA3);
`ifdef CONV_WR_ARB_RR_EN
    exp_w[0] = 2'd1; exp_w[1] = 2'd3; exp_w[2] = 2'd1;
`else
    exp_w[0] = 2'd1; exp_w[1] = 2'd1; exp_w[2] = 2'd1;
`endif
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      w = exp_w[k];
      push(4'b0001 << w, (w == 2'd1) ? 4'b0001 : 4'b1000, (w == 2'd1) ? 8'hA1 : 8'hA3);
      wait_ack(n);
      req[w] = 1'b0;
      if (w == 2'd1) begin
        @(negedge rcc_clk);
        req[1] = 1'b1;
      end
    end
    req = 4'b0000;
    repeat (4) @(negedge rcc_clk);

    // Reset asserted in the middle of a WRITE cycle
    set_req(0, 2'd2, 8'h77);
    req = 4'b0001;
    push(4'b0001, 4'b0100, 8'h77);
    wait_ack(n);
    #2 rcc_rst_n = 1'b0;
    #1;
    check("midrst_reg_en", {28'd0, reg_en}, 32'd0);
    check("midrst_ack", {28'd0, ack}, 32'd0);
    check("midrst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge rcc_clk);
    rcc_rst_n = 1'b1;
    push(4'b0001, 4'b0100, 8'h77);
    wait_ack(n);
    check("post_rst_latency", n, 1);
    req = 4'b0000;
    @(negedge rcc_clk);
    check("post_rst_wr_cnt", {24'd0, wr_cnt}, 32'd1);

    // 256 writes wrap the counter
    do_reset();
    set_req(0, 2'd3, 8'h00);
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      push(4'b0001, 4'b1000, 8'(i));
      wait_ack(n);
      if (i == 255) check("wrap_pre_cnt", {24'd0, wr_cnt}, 32'd255);
      set_req(0, 2'd3, 8'(i + 1));
    end
    req = 4'b0000;
    @(negedge rcc_clk);
    check("wrap_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    check("wrap_reg_din", {24'd0, reg_din}, 32'hFF);
    check("wrap_hold3", {24'd0, hold[3]}, 32'hFF);
    repeat (3) @(negedge rcc_clk);
    check("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
